sqrt_calculator: RTL
====================

// Module: sqrt_calculator
// PURPOSE
//  Integer square-root stage fed directly by the byte-to-word receiver.
//  - Consumes each assembled 32-bit word on a rising edge of in_data_ready.
//  - Computes floor(sqrt(x)) and its remainder with a digit-by-digit (restoring) algorithm, one result bit per clock.
//  - Presents root and remainder to the downstream transmitter/display with a one-cycle out_data_ready pulse.
// PARAMETERS
//  IN_WIDTH   32   radicand width; must be even and >= 4
//  OUT_WIDTH  IN_WIDTH/2 (localparam)   root width, which is also the iteration count
// PORTS
//  clk             in   1            single clock; all logic on posedge
//  rst             in   1            synchronous, active-high reset
//  in_data         in   IN_WIDTH     radicand from the receiver
//  in_data_ready   in   1            receiver word-valid; a new word is signalled by its rising edge
//  out_root        out  OUT_WIDTH    floor(sqrt(in_data)), or the rounded root (see CONFIGURATION)
//  out_remainder   out  OUT_WIDTH+1  in_data - floor_root^2; range 0..2*floor_root
//  out_data_ready  out  1            one-clock pulse; outputs are valid from this cycle on
//  busy            out  1            high in CALC and DONE
//  overrun         out  1            sticky; set when a word arrives while busy
// BEHAVIOUR
//  Reset: all outputs 0, state = IDLE, internal regs 0, in_data_ready edge-detect register 0.
//    Reset overrides everything, including mid-CALC; the partial result is discarded and no pulse is issued.
//  Edge detect: start = in_data_ready & ~rdy_q. A level held high for N cycles counts as one word.
//  FSM:
//    IDLE -> CALC on start. Capture in_data into the radicand shift reg; clear rem, root, and the iteration counter.
//    CALC runs for exactly OUT_WIDTH cycles. Per cycle:
//      rem_t = {rem, rad[MSB:MSB-1]}; rad <<= 2; trial = {root, 2'b01}.
//      If rem_t >= trial: rem = rem_t - trial, root = {root, 1}.
//      Else: rem = rem_t, root = {root, 0}.
//      Working rem width is OUT_WIDTH+2; no truncation is allowed.
//    CALC -> DONE after iteration OUT_WIDTH-1.
//    DONE (1 cycle): register out_root and out_remainder, pulse out_data_ready, then go to IDLE.
//  Latency: the pulse asserts OUT_WIDTH+1 clocks after the capturing edge (17 for IN_WIDTH=32).
//    The next start is accepted in the cycle after DONE.
//  Overrun: a start seen in CALC or DONE is ignored and sets overrun = 1.
//    The current computation is unaffected. overrun clears only on rst.
//  out_root and out_remainder hold their last value between results. out_data_ready is never high 2 cycles in a row.
//  Boundaries:
//    x = 0 gives root 0, rem 0.
//    x = 2^IN_WIDTH-1 gives root 2^OUT_WIDTH-1, rem 2^(OUT_WIDTH+1)-2 (full remainder width used).
//    Perfect squares give rem 0.
// CONFIGURATION
//  SQRT_ROUND_EN defined:
//    out_root = floor_root + 1 when rem > floor_root (round to nearest, ties impossible), else floor_root.
//    Saturates at 2^OUT_WIDTH-1.
//    out_remainder still reports the floor-based remainder.
//    The adjustment is applied in DONE; latency is unchanged.
//  SQRT_ROUND_EN undefined: out_root = floor_root. No extra comparator or adder is built.
// TESTING
//  T1 in_data=100, 1-cycle ready pulse -> after 17 clks: root=10, rem=0, pulse 1 cycle, busy back to 0.
//  T2 in_data=99 -> root=9, rem=18; with SQRT_ROUND_EN root=10.
//     in_data=0 -> root=0, rem=0.
//  T3 in_data=32'hFFFFFFFF -> root=65535, rem=131070; with SQRT_ROUND_EN root stays 65535 (saturated).
//  T4 ready held 2 cycles with in_data=88 -> exactly one result: root=9, rem=7.
//     A second rising edge (in_data=54) 5 clks after the capture -> ignored, overrun=1, result for 88 still correct.
//  T5 rst asserted for 1 cycle at iteration 8 of in_data=10 -> no pulse, all outputs 0.
//     Next word 20 -> root=4, rem=4.
//  T6 back-to-back words 10, 20, 88, 54, 100 spaced 20 clks -> roots 3,4,9,7,10 and rems 1,4,7,5,0.
//     overrun stays 0.

Source files
------------

// File: rtl/sqrt_calculator.sv
// sqrt_calculator: integer square root of a word from the byte-to-word receiver,
// produced by the restoring digit-by-digit method at one root bit per clock.
//
// Optional feature: define SQRT_ROUND_EN to round out_root to nearest
// (saturating); out_remainder always reports the floor-based remainder.
//
// Ports:
//   clk             in   single clock, posedge
//   rst             in   synchronous active-high reset
//   in_data         in   radicand (IN_WIDTH bits)
//   in_data_ready   in   word valid; its rising edge starts a computation
//   out_root        out  root (IN_WIDTH/2 bits)
//   out_remainder   out  in_data - floor_root^2 (IN_WIDTH/2+1 bits)
//   out_data_ready  out  one-cycle result pulse
//   busy            out  high while computing or presenting a result
//   overrun         out  sticky; a word arrived while busy
module sqrt_calculator #(
  parameter int unsigned IN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_data_ready,
  output logic [IN_WIDTH/2-1:0] out_root,
  output logic [IN_WIDTH/2:0]   out_remainder,
  output logic                  out_data_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;
  localparam int unsigned REM_W     = OUT_WIDTH + 2;
  localparam int unsigned RT_W      = REM_W + 2;
  localparam int unsigned CNT_W     = (OUT_WIDTH > 2) ? $clog2(OUT_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic [IN_WIDTH-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [OUT_WIDTH-1:0]  root_q, root_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  out_root_q, out_root_d;
  logic [OUT_WIDTH:0]    out_rem_q, out_rem_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  start_c;
  logic [RT_W-1:0]       rem_t_c;
  logic [RT_W-1:0]       trial_c;
  logic [RT_W-1:0]       diff_c;
  logic                  ge_c;
  logic [OUT_WIDTH-1:0]  root_fin_c;

  assign start_c = in_data_ready & ~rdy_q;

  // One restoring step: bring down the next two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_t_c = {rem_q, rad_q[IN_WIDTH-1 -: 2]};
    trial_c = RT_W'({root_q, 2'b01});
    diff_c  = rem_t_c - trial_c;
    ge_c    = (rem_t_c >= trial_c);
  end

`ifdef SQRT_ROUND_EN
  // Round up when rem exceeds root (x is closer to (root+1)^2); never wrap past all-ones.
  always_comb begin
    root_fin_c = root_q;
    if ((rem_q > REM_W'(root_q)) && (root_q != '1)) begin
      root_fin_c = root_q + OUT_WIDTH'(1);
    end
  end
`else
  assign root_fin_c = root_q;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    out_root_d = out_root_q;
    out_rem_d  = out_rem_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q | (start_c & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = S_CALC;
          rad_d   = in_data;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        rad_d = rad_q << 2;
        if (ge_c) begin
          rem_d  = REM_W'(diff_c);
          root_d = {root_q[OUT_WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = REM_W'(rem_t_c);
          root_d = {root_q[OUT_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_root_d = root_fin_c;
        out_rem_d  = rem_q[OUT_WIDTH:0];
        valid_d    = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      out_root_q <= '0;
      out_rem_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= in_data_ready;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      out_root_q <= out_root_d;
      out_rem_q  <= out_rem_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_root       = out_root_q;
  assign out_remainder  = out_rem_q;
  assign out_data_ready = valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule
